// File: rtl/gpio_arb_pkg12.sv
// Shared types and helpers for the GPIO APB arbiter/sequencer.
package gpio_arb_pkg12;

    // APB sequencing states: SETUP drives psel only, ACCESS adds penable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF = 2;
    localparam int ADDR_W_DEF  = 6;
    localparam int DATA_W_DEF  = 32;

    // Width of a requester index; never below one bit so single-bit vectors stay legal.
    function automatic int idx_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_lock_arb12.sv
// Round-robin arbiter with a sticky lock owner. Grants only while i_en is high
// (the sequencer's grant points); the pointer and owner move only on those cycles.
module rr_lock_arb12
    import gpio_arb_pkg12::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [N-1:0]  i_valid,
    input  logic [N-1:0]  i_lock,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_vld
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic          r_own_vld;
    logic          w_lock_active;
    logic [N-1:0]  w_elig;
    logic          w_found;
    logic [IW-1:0] w_idx;
    logic [N-1:0]  w_grant;
    int            w_j;

    // Eligibility and round-robin search from the pointer; a live lock narrows the field to its owner.
    always_comb begin
        w_lock_active = r_own_vld && i_lock[r_owner];
        w_elig        = i_valid;
        w_found       = 1'b0;
        w_idx         = {IW{1'b0}};
        w_j           = 0;
        w_grant       = {N{1'b0}};
        if (w_lock_active) begin
            w_elig = i_valid & ({{(N-1){1'b0}}, 1'b1} << r_owner);
        end else begin
            w_elig = i_valid;
        end
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end else begin
                w_j = w_j;
            end
            if (!w_found && i_en && w_elig[w_j]) begin
                w_found = 1'b1;
                w_idx   = IW'(w_j);
            end else begin
                w_found = w_found;
            end
        end
        if (w_found) begin
            w_grant[w_idx] = 1'b1;
        end else begin
            w_grant = {N{1'b0}};
        end
    end

    // Pointer advances past each winner; owner is dropped once its lock falls and taken by a locking winner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= {IW{1'b0}};
            r_owner   <= {IW{1'b0}};
            r_own_vld <= 1'b0;
        end else if (i_en) begin
            if (r_own_vld && !i_lock[r_owner]) begin
                r_own_vld <= 1'b0;
            end
            if (w_found) begin
                if (w_idx == IW'(N - 1)) begin
                    r_ptr <= {IW{1'b0}};
                end else begin
                    r_ptr <= w_idx + IW'(1);
                end
                if (i_lock[w_idx]) begin
                    r_own_vld <= 1'b1;
                    r_owner   <= w_idx;
                end
            end
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_grant_vld = w_found;

endmodule

// File: rtl/gpio_apb_arb12.sv
// APB arbiter/sequencer in front of the GPIO slave port. Every transfer is
// SETUP + ACCESS (the slave has no pready); the owner gets a one-cycle response.
module gpio_apb_arb12
    import gpio_arb_pkg12::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                        pclk12,
    input  logic                        n_p_reset12,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_W-1:0]           paddr,
    output logic [DATA_W-1:0]           pwdata,
    input  logic [DATA_W-1:0]           prdata,
    output logic                        busy
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic                 w_grant_pt;
    logic                 w_arb_en;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IW-1:0]        w_gnt_idx;
    logic                 w_gnt_vld;
    logic [IW-1:0]        r_cur;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic                 r_busy;
    logic [ADDR_W-1:0]    r_paddr;
    logic [DATA_W-1:0]    r_pwdata;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic [NUM_REQ-1:0]   w_rsp_vec;

    // New commands are taken only when the APB port is free next cycle; never while in reset.
    assign w_grant_pt = (r_state == ST_IDLE) || (r_state == ST_ACCESS);
    assign w_arb_en   = w_grant_pt && n_p_reset12;

    rr_lock_arb12 #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .i_clk       (pclk12),
        .i_rst_n     (n_p_reset12),
        .i_en        (w_arb_en),
        .i_valid     (req_valid),
        .i_lock      (req_lock),
        .o_grant     (w_grant),
        .o_grant_idx (w_gnt_idx),
        .o_grant_vld (w_gnt_vld)
    );

    // Next-state logic: ACCESS chains straight into SETUP when another command is granted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_gnt_vld) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completion pulse goes to whoever owns the transfer currently in ACCESS.
    always_comb begin
        w_rsp_vec = {NUM_REQ{1'b0}};
        if (r_state == ST_ACCESS) begin
            w_rsp_vec[r_cur] = 1'b1;
        end else begin
            w_rsp_vec = {NUM_REQ{1'b0}};
        end
    end

    // State and APB drive registers; command fields are captured only on the accepting edge.
    always_ff @(posedge pclk12 or negedge n_p_reset12) begin
        if (!n_p_reset12) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_busy    <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= {ADDR_W{1'b0}};
            r_pwdata  <= {DATA_W{1'b0}};
            r_cur     <= {IW{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= (w_state_nxt != ST_IDLE);
            r_penable <= (w_state_nxt == ST_ACCESS);
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_gnt_vld) begin
                r_pwrite <= req_write[w_gnt_idx];
                r_paddr  <= req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
                r_pwdata <= req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
                r_cur    <= w_gnt_idx;
            end
        end
    end

    // Response registers: read data sampled at the end of ACCESS, writes return zero.
    always_ff @(posedge pclk12 or negedge n_p_reset12) begin
        if (!n_p_reset12) begin
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            r_rsp_valid <= w_rsp_vec;
            if (r_state == ST_ACCESS) begin
                r_rsp_rdata <= r_pwrite ? {DATA_W{1'b0}} : prdata;
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign busy      = r_busy;

endmodule
